// File: rtl/jaxa_timecode_scheduler.sv
// Avalon-MM programmable SpaceWire time-code scheduler: periodic or one-shot
// tick_in requests for the JAXA codec, gated by link state, with overrun tracking.
module jaxa_timecode_scheduler #(
  parameter int HOLDOFF  = 16,
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        link_running,
  output logic        tick_in,
  output logic [5:0]  time_in,
  output logic [1:0]  control_flags_in
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  logic [1:0]          state;
  logic [HW-1:0]       hold_cnt;
  logic [PERIOD_W-1:0] period_r;
  logic [PERIOD_W-1:0] per_cnt;
  logic                en_r;
  logic                auto_inc_r;
  logic [1:0]          flags_r;
  logic [5:0]          time_r;
  logic                pending;
  logic                overrun;
  logic [15:0]         sent_cnt;

  logic wr, wr_ctrl, wr_period, wr_time, wr_status;
  logic fire_req, en_rise, per_load, expire, issue, req_event;
  logic unused_wd;

  assign wr        = chipselect && !write_n;
  assign wr_ctrl   = wr && (address == 2'd0);
  assign wr_period = wr && (address == 2'd1);
  assign wr_time   = wr && (address == 2'd2);
  assign wr_status = wr && (address == 2'd3);
  assign unused_wd = ^writedata;

  assign fire_req  = wr_ctrl && writedata[2];
  assign en_rise   = wr_ctrl && writedata[0] && !en_r;
  assign per_load  = en_rise || (wr_period && en_r);
  assign expire    = en_r && (period_r != '0) && (per_cnt == '0) && !per_load;
  assign issue     = (state == ST_ISSUE);
  // Fire and expiry in the same cycle collapse into a single request.
  assign req_event = fire_req || expire;

  assign tick_in          = issue;
  assign time_in          = time_r;
  assign control_flags_in = flags_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_r       <= 1'b0;
      auto_inc_r <= 1'b0;
      flags_r    <= 2'b00;
      period_r   <= '0;
    end else begin
      if (wr_ctrl) begin
        en_r       <= writedata[0];
        auto_inc_r <= writedata[1];
        flags_r    <= writedata[5:4];
      end
      if (wr_period) period_r <= writedata[PERIOD_W-1:0];
    end
  end

  // Period counter: reload on enable, on period rewrite while enabled, and on expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt <= '0;
    end else if (en_rise) begin
      per_cnt <= period_r - PERIOD_W'(1);
    end else if (per_load) begin
      per_cnt <= writedata[PERIOD_W-1:0] - PERIOD_W'(1);
    end else if (en_r && (period_r != '0)) begin
      if (per_cnt == '0) per_cnt <= period_r - PERIOD_W'(1);
      else               per_cnt <= per_cnt - PERIOD_W'(1);
    end
  end

  // A request issued this cycle frees the slot, so a coincident new event queues cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending && !issue) || req_event;
      if (req_event && pending && !issue) overrun <= 1'b1;
      else if (wr_status && writedata[1]) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_r   <= 6'd0;
      sent_cnt <= 16'd0;
    end else begin
      if (wr_time) time_r <= writedata[5:0];
      else if (issue && auto_inc_r) time_r <= time_r + 6'd1;
      if (issue) sent_cnt <= sent_cnt + 16'd1;
    end
  end

  // Holdoff expiry goes straight to ISSUE when a request is waiting, keeping spacing at HOLDOFF+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending && link_running) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          state    <= ST_HOLD;
          hold_cnt <= HW'(HOLDOFF - 1);
        end
        ST_HOLD: begin
          if (hold_cnt == '0) state <= (pending && link_running) ? ST_ISSUE : ST_IDLE;
          else                hold_cnt <= hold_cnt - HW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata = {26'd0, flags_r, 2'b00, auto_inc_r, en_r};
      2'd1: readdata = 32'(period_r);
      2'd2: readdata = {26'd0, time_r};
      2'd3: readdata = {8'd0, sent_cnt, 6'd0, overrun, pending};
      default: readdata = 32'd0;
    endcase
  end

endmodule
